// File: rtl/rs_symbol_buffer_ctrl.sv
// rtl/rs_symbol_buffer_ctrl.sv - symbol RAM fill/replay controller for the RS Euclidean decoder
//
// Purpose:
//    The controller writes one received codeword into a single-port symbol RAM,
//    one symbol per accepted input beat. On command it replays the stored
//    codeword in forward or reverse address order. Output flags are aligned to
//    the RAM's one-cycle registered read latency.
//
// Ports:
//    clk, rst        clock, asynchronous active-high reset
//    in_valid/in_data/in_ready   input symbol stream
//    rd_start, rd_reverse        replay command and replay direction
//    abort           synchronous return to IDLE
//    ram_ren/ram_wen/ram_addr/ram_din/ram_dout   symbol RAM port
//    out_valid/out_data/out_last replayed symbol stream
//    full, done      codeword stored / final symbol replayed
module rs_symbol_buffer_ctrl #(
   parameter int WORDS = 32,
   parameter int AW    = 5,
   parameter int DW    = 16,
   parameter int LEN   = 31
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          in_ready,
   input  logic          rd_start,
   input  logic          rd_reverse,
   input  logic          abort,
   output logic          ram_ren,
   output logic          ram_wen,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_din,
   input  logic [DW-1:0] ram_dout,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   output logic          out_last,
   output logic          full,
   output logic          done
);

   // Index of the final symbol. It is clamped to the RAM depth, so an oversized LEN
   // cannot address past the end of the RAM.
   localparam int              LAST     = (LEN <= WORDS) ? LEN - 1 : WORDS - 1;
   localparam logic [AW:0]     CNT_LAST = (AW + 1)'(LAST);
   localparam logic [AW-1:0]   PTR_LAST = AW'(LAST);

   typedef enum logic [1:0] {IDLE, FILL, FULL, DRAIN} state_t;

   state_t        state_q;
   logic [AW:0]   wr_cnt_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   rd_cnt_q;
   logic          rev_q;
   logic          out_valid_q;
   logic          out_last_q;
   logic          done_q;

   logic          accept;
   logic          rd_last;

   // in_ready is held low while rst is asserted. No beat is consumed until the reset is released.
   assign in_ready  = ~rst & ((state_q == IDLE) | (state_q == FILL));
   // abort masks both RAM strobes in the cycle where it is asserted.
   assign accept    = in_valid & in_ready & ~abort;
   assign ram_wen   = accept;
   assign ram_ren   = (state_q == DRAIN) & ~abort;
   assign ram_din   = in_data;
   assign full      = (state_q == FULL);
   assign rd_last   = (rd_cnt_q == CNT_LAST);

   // The read data already carries one cycle of RAM latency. It passes straight through.
   assign out_data  = ram_dout;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign done      = done_q;

   always_comb begin
      ram_addr = '0;
      case (state_q)
         IDLE, FILL: ram_addr = wr_cnt_q[AW-1:0];
         DRAIN:      ram_addr = rd_ptr_q;
         default:    ram_addr = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         wr_cnt_q    <= '0;
         rd_ptr_q    <= '0;
         rd_cnt_q    <= '0;
         rev_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         // The output stage follows the read strobe by one cycle, matching the RAM latency.
         out_valid_q <= ram_ren;
         out_last_q  <= ram_ren & rd_last;
         done_q      <= ram_ren & rd_last;

         if (abort) begin
            state_q  <= IDLE;
            wr_cnt_q <= '0;
            rd_ptr_q <= '0;
            rd_cnt_q <= '0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (accept) begin
                     wr_cnt_q <= (AW + 1)'(1);
                     state_q  <= (LAST == 0) ? FULL : FILL;
                  end
               end
               FILL: begin
                  if (accept) begin
                     wr_cnt_q <= wr_cnt_q + 1'b1;
                     if (wr_cnt_q == CNT_LAST) begin
                        state_q <= FULL;
                     end
                  end
               end
               FULL: begin
                  if (rd_start) begin
                     rev_q    <= rd_reverse;
                     rd_ptr_q <= rd_reverse ? PTR_LAST : '0;
                     rd_cnt_q <= '0;
                     state_q  <= DRAIN;
                  end
               end
               DRAIN: begin
                  // The last read returns to IDLE. This lets a new fill start at address 0
                  // while the final symbol is still in the output stage.
                  if (rd_last) begin
                     state_q  <= IDLE;
                     wr_cnt_q <= '0;
                     rd_cnt_q <= '0;
                     rd_ptr_q <= '0;
                  end else begin
                     rd_cnt_q <= rd_cnt_q + 1'b1;
                     rd_ptr_q <= rev_q ? rd_ptr_q - 1'b1 : rd_ptr_q + 1'b1;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_rs_symbol_buffer_ctrl.sv
// tb/tb_rs_symbol_buffer_ctrl.sv - self-checking bench for rs_symbol_buffer_ctrl
module tb_rs_symbol_buffer_ctrl;

   localparam int WORDS = 32;
   localparam int AW    = 5;
   localparam int DW    = 16;
   localparam int LEN   = 31;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_ready;
   logic          rd_start = 1'b0;
   logic          rd_reverse = 1'b0;
   logic          abort = 1'b0;
   logic          ram_ren;
   logic          ram_wen;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic [DW-1:0] ram_dout;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          full;
   logic          done;

   int passed = 0;
   int total  = 0;

   // Behavioural symbol RAM: registered read, output floats when no read was issued.
   logic [DW-1:0] mem [WORDS];
   logic [DW-1:0] rd_q = '0;
   logic          rd_v = 1'b0;

   // Reference contents: what each RAM address must hold, per the accepted stream.
   logic [DW-1:0] model_mem [WORDS];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_wen) mem[ram_addr] <= ram_din;
      if (ram_ren) rd_q <= mem[ram_addr];
      rd_v <= ram_ren;
   end
   assign ram_dout = rd_v ? rd_q : 'z;

   rs_symbol_buffer_ctrl #(.WORDS(WORDS), .AW(AW), .DW(DW), .LEN(LEN)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .rd_start(rd_start), .rd_reverse(rd_reverse), .abort(abort),
      .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
      .ram_din(ram_din), .ram_dout(ram_dout),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
      .full(full), .done(done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Push symbols from index start_cnt up to stop_cnt. mode 0 sends 0x1000+i and mode 1 sends random data.
   // With gapped=1, in_valid is toggled randomly and rd_start is pulsed during the fill.
   task automatic fill(input int start_cnt, input int stop_cnt, input bit mode, input bit gapped);
      int cnt = start_cnt;
      int guard = 0;
      logic [DW-1:0] d;
      logic v;
      while (cnt < stop_cnt && guard < 2000) begin
         guard++;
         v = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
         d = mode ? DW'($urandom) : DW'(16'h1000 + cnt);
         in_valid = v;
         in_data  = d;
         rd_start = gapped ? ($urandom_range(0, 5) == 0) : 1'b0;
         @(negedge clk);
         chk("fill_in_ready", 32'(in_ready), 32'd1);
         chk("fill_wen", 32'(ram_wen), 32'(v));
         chk("fill_ren", 32'(ram_ren), 32'd0);
         chk("fill_full", 32'(full), 32'd0);
         if (v) begin
            chk("fill_addr", 32'(ram_addr), 32'(cnt));
            chk("fill_din", 32'(ram_din), 32'(d));
         end
         next_cycle();
         if (v) begin
            model_mem[cnt] = d;
            cnt++;
         end
      end
      chk("fill_bounded", 32'(cnt), 32'(stop_cnt));
      in_valid = 1'b0;
      rd_start = 1'b0;
      if (stop_cnt == LEN) begin
         @(negedge clk);
         chk("full_after_fill", 32'(full), 32'd1);
         chk("in_ready_when_full", 32'(in_ready), 32'd0);
         next_cycle();
      end
   endtask

   // While FULL, in_valid held high must neither write nor be accepted.
   task automatic full_hold(input int n);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_data  = DW'($urandom);
         @(negedge clk);
         chk("hold_wen", 32'(ram_wen), 32'd0);
         chk("hold_in_ready", 32'(in_ready), 32'd0);
         chk("hold_full", 32'(full), 32'd1);
         chk("hold_ren", 32'(ram_ren), 32'd0);
         chk("hold_addr", 32'(ram_addr), 32'd0);
         next_cycle();
      end
      in_valid = 1'b0;
   endtask

   // Replay the stored codeword. abort_cyc != 0 asserts abort in that cycle, counting from
   // the rd_start edge. b2b starts a new fill in the cycle that shows the last symbol.
   task automatic replay(input bit rev, input int abort_cyc, input bit b2b);
      logic [DW-1:0] exp_sym [LEN];
      bit exp_ren;
      bit exp_ov;
      for (int k = 0; k < LEN; k++) exp_sym[k] = model_mem[rev ? LEN - 1 - k : k];
      rd_start   = 1'b1;
      rd_reverse = rev;
      @(negedge clk);
      chk("start_ren", 32'(ram_ren), 32'd0);
      chk("start_full", 32'(full), 32'd1);
      next_cycle();
      rd_start   = 1'b0;
      rd_reverse = $urandom_range(0, 1);
      for (int cyc = 1; cyc <= LEN + 1; cyc++) begin
         if (cyc == abort_cyc) abort = 1'b1;
         if (b2b && cyc == LEN + 1) begin
            in_valid = 1'b1;
            in_data  = DW'($urandom);
         end
         @(negedge clk);
         exp_ren = (cyc <= LEN) && (cyc != abort_cyc);
         exp_ov  = (cyc >= 2);
         chk("drain_ren", 32'(ram_ren), 32'(exp_ren));
         if (exp_ren) chk("drain_addr", 32'(ram_addr), 32'(rev ? LEN - cyc : cyc - 1));
         chk("drain_out_valid", 32'(out_valid), 32'(exp_ov));
         if (exp_ov) begin
            chk("drain_out_data", 32'(out_data), 32'(exp_sym[cyc - 2]));
            chk("drain_out_last", 32'(out_last), 32'(cyc == LEN + 1));
            chk("drain_done", 32'(done), 32'(cyc == LEN + 1));
         end
         if (b2b && cyc == LEN + 1) begin
            chk("b2b_wen", 32'(ram_wen), 32'd1);
            chk("b2b_addr", 32'(ram_addr), 32'd0);
            chk("b2b_in_ready", 32'(in_ready), 32'd1);
         end
         next_cycle();
         if (b2b && cyc == LEN + 1) begin
            model_mem[0] = in_data;
            in_valid = 1'b0;
         end
         if (cyc == abort_cyc) begin
            abort = 1'b0;
            @(negedge clk);
            chk("abort_out_valid", 32'(out_valid), 32'd0);
            chk("abort_out_last", 32'(out_last), 32'd0);
            chk("abort_done", 32'(done), 32'd0);
            chk("abort_in_ready", 32'(in_ready), 32'd1);
            chk("abort_full", 32'(full), 32'd0);
            chk("abort_ren", 32'(ram_ren), 32'd0);
            next_cycle();
            break;
         end
      end
      if (abort_cyc == 0 && !b2b) begin
         @(negedge clk);
         chk("post_in_ready", 32'(in_ready), 32'd1);
         chk("post_out_valid", 32'(out_valid), 32'd0);
         chk("post_full", 32'(full), 32'd0);
      end
   endtask

   initial begin
      // The reset is released one time unit after a rising edge.
      #12;
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_ren", 32'(ram_ren), 32'd0);
      chk("rst_wen", 32'(ram_wen), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_out_last", 32'(out_last), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_addr", 32'(ram_addr), 32'd0);
      next_cycle();

      // Ordered fill, ignored input while FULL, then forward replay.
      fill(0, LEN, 1'b0, 1'b0);
      full_hold(3);
      replay(1'b0, 0, 1'b0);

      // Gapped refill with stray rd_start pulses, then reverse replay.
      fill(0, LEN, 1'b0, 1'b1);
      replay(1'b1, 0, 1'b0);

      // Random data fill, then abort during replay of symbol 10. The following fill restarts at address 0.
      fill(0, LEN, 1'b1, 1'b1);
      full_hold(2);
      replay(1'b0, 12, 1'b0);

      // Asynchronous reset partway through a fill.
      fill(0, 15, 1'b1, 1'b1);
      in_valid = 1'b1;
      in_data  = DW'($urandom);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_wen", 32'(ram_wen), 32'd0);
      chk("async_rst_ren", 32'(ram_ren), 32'd0);
      chk("async_rst_full", 32'(full), 32'd0);
      chk("async_rst_out_valid", 32'(out_valid), 32'd0);
      chk("async_rst_addr", 32'(ram_addr), 32'd0);
      in_valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      fill(0, LEN, 1'b1, 1'b0);
      replay(1'b1, 0, 1'b1);

      // The symbol written in the back-to-back cycle is index 0 of the next codeword.
      fill(1, LEN, 1'b1, 1'b1);
      replay(1'b0, 0, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
